// File: rtl/coll_pkg.sv
// Shared types for the collision pair issuer: operand width, object record, FSM states.
package coll_pkg;

    localparam int W           = 16;
    localparam int TIMEOUT_DEF = 64;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] vx;
        logic [W-1:0] vy;
    } obj_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        REPORT,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/coll_obj_table.sv
// Object state register file: one write port, two combinational read ports.
// Writes land on the next edge; the table is cleared by synchronous reset.
module coll_obj_table
    import coll_pkg::*;
#(
    parameter int N_OBJ = 8,
    parameter int IDX_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  obj_t             wr_dat,
    input  logic [IDX_W-1:0] rd_i_idx,
    input  logic [IDX_W-1:0] rd_j_idx,
    output obj_t             rd_i_dat,
    output obj_t             rd_j_dat
);

    obj_t mem_q [N_OBJ];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < N_OBJ; k++) begin
                mem_q[k] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_idx} < (IDX_W+1)'(N_OBJ))) begin
            mem_q[wr_idx] <= wr_dat;
        end
    end

    assign rd_i_dat = mem_q[rd_i_idx];
    assign rd_j_dat = mem_q[rd_j_idx];

endmodule

// File: rtl/coll_pair_issuer.sv
// Walks every i<j object pair through the collision detector and streams one verdict per pair.
// start->det_in_rdy 2 cycles; each pair waits on det_out_rdy for at most TIMEOUT cycles.
module coll_pair_issuer
    import coll_pkg::*;
#(
    parameter int N_OBJ   = 8,
    parameter int IDX_W   = 3,
    parameter int W       = coll_pkg::W,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             obj_wr_en,
    input  logic [IDX_W-1:0] obj_wr_idx,
    input  logic [W-1:0]     obj_wr_x,
    input  logic [W-1:0]     obj_wr_y,
    input  logic [W-1:0]     obj_wr_vx,
    input  logic [W-1:0]     obj_wr_vy,
    input  logic [W-1:0]     r2_in,
    input  logic [IDX_W:0]   num_obj,
    input  logic             start,
    output logic             busy,
    output logic [W-1:0]     det_x1,
    output logic [W-1:0]     det_y1,
    output logic [W-1:0]     det_x2,
    output logic [W-1:0]     det_y2,
    output logic [W-1:0]     det_vx1,
    output logic [W-1:0]     det_vy1,
    output logic [W-1:0]     det_vx2,
    output logic [W-1:0]     det_vy2,
    output logic [W-1:0]     det_r2,
    output logic             det_in_rdy,
    input  logic             det_trial,
    input  logic             det_out_rdy,
    output logic             pair_valid,
    output logic [IDX_W-1:0] pair_i,
    output logic [IDX_W-1:0] pair_j,
    output logic             pair_hit,
    output logic             pair_timeout,
    output logic [7:0]       hit_count,
    output logic             done
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int NW    = IDX_W + 1;

    state_t           state_q;
    logic [IDX_W-1:0] i_q, j_q;
    logic [NW-1:0]    n_q;
    logic [W-1:0]     r2_q;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             hit_cap_q, tmo_cap_q;

    obj_t             op1_q, op2_q;
    logic [W-1:0]     det_r2_q;
    logic             busy_q, det_in_rdy_q, pair_valid_q, pair_hit_q, pair_timeout_q, done_q;
    logic [IDX_W-1:0] pair_i_q, pair_j_q;
    logic [7:0]       hit_count_q;

    obj_t             wr_dat, rd_i_dat, rd_j_dat;
    logic [NW-1:0]    n_clamp;

    assign wr_dat  = '{x: obj_wr_x, y: obj_wr_y, vx: obj_wr_vx, vy: obj_wr_vy};
    assign n_clamp = (num_obj > NW'(N_OBJ)) ? NW'(N_OBJ) : num_obj;

    // busy_q is high in every non-IDLE state, so this gates writes to idle only.
    coll_obj_table #(
        .N_OBJ (N_OBJ),
        .IDX_W (IDX_W)
    ) u_table (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (obj_wr_en && !busy_q),
        .wr_idx   (obj_wr_idx),
        .wr_dat   (wr_dat),
        .rd_i_idx (i_q),
        .rd_j_idx (j_q),
        .rd_i_dat (rd_i_dat),
        .rd_j_dat (rd_j_dat)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            i_q            <= '0;
            j_q            <= '0;
            n_q            <= '0;
            r2_q           <= '0;
            tmo_cnt_q      <= '0;
            hit_cap_q      <= 1'b0;
            tmo_cap_q      <= 1'b0;
            op1_q          <= '0;
            op2_q          <= '0;
            det_r2_q       <= '0;
            busy_q         <= 1'b0;
            det_in_rdy_q   <= 1'b0;
            pair_valid_q   <= 1'b0;
            pair_i_q       <= '0;
            pair_j_q       <= '0;
            pair_hit_q     <= 1'b0;
            pair_timeout_q <= 1'b0;
            hit_count_q    <= '0;
            done_q         <= 1'b0;
        end else begin
            pair_valid_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    // busy stays up through the done cycle, which is spent here.
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (start) begin
                        r2_q        <= r2_in;
                        n_q         <= n_clamp;
                        i_q         <= '0;
                        j_q         <= IDX_W'(1);
                        hit_count_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= (n_clamp < NW'(2)) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    op1_q        <= rd_i_dat;
                    op2_q        <= rd_j_dat;
                    det_r2_q     <= r2_q;
                    det_in_rdy_q <= 1'b1;
                    state_q      <= ISSUE;
                end
                ISSUE: begin
                    if (det_out_rdy) begin
                        hit_cap_q    <= det_trial;
                        tmo_cap_q    <= 1'b0;
                        det_in_rdy_q <= 1'b0;
                        state_q      <= REPORT;
                    end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        hit_cap_q    <= 1'b0;
                        tmo_cap_q    <= 1'b1;
                        det_in_rdy_q <= 1'b0;
                        state_q      <= REPORT;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                REPORT: begin
                    pair_valid_q   <= 1'b1;
                    pair_i_q       <= i_q;
                    pair_j_q       <= j_q;
                    pair_hit_q     <= hit_cap_q;
                    pair_timeout_q <= tmo_cap_q;
                    if (hit_cap_q && (hit_count_q != 8'hFF)) begin
                        hit_count_q <= hit_count_q + 8'd1;
                    end
                    tmo_cnt_q <= '0;
                    state_q   <= NEXT;
                end
                NEXT: begin
                    if ({1'b0, j_q} < (n_q - NW'(1))) begin
                        j_q     <= j_q + IDX_W'(1);
                        state_q <= LOAD;
                    end else if ({1'b0, i_q} < (n_q - NW'(2))) begin
                        i_q     <= i_q + IDX_W'(1);
                        j_q     <= IDX_W'({1'b0, i_q} + NW'(2));
                        state_q <= LOAD;
                    end else begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign det_x1       = op1_q.x;
    assign det_y1       = op1_q.y;
    assign det_vx1      = op1_q.vx;
    assign det_vy1      = op1_q.vy;
    assign det_x2       = op2_q.x;
    assign det_y2       = op2_q.y;
    assign det_vx2      = op2_q.vx;
    assign det_vy2      = op2_q.vy;
    assign det_r2       = det_r2_q;
    assign det_in_rdy   = det_in_rdy_q;
    assign pair_valid   = pair_valid_q;
    assign pair_i       = pair_i_q;
    assign pair_j       = pair_j_q;
    assign pair_hit     = pair_hit_q;
    assign pair_timeout = pair_timeout_q;
    assign hit_count    = hit_count_q;
    assign done         = done_q;

endmodule

// File: tb/tb_coll_pair_issuer.sv
// Directed bench for coll_pair_issuer with a latency-programmable detector model.
module tb_coll_pair_issuer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        obj_wr_en = 1'b0;
    logic [2:0]  obj_wr_idx = '0;
    logic [15:0] obj_wr_x = '0, obj_wr_y = '0, obj_wr_vx = '0, obj_wr_vy = '0;
    logic [15:0] r2_in = '0;
    logic [3:0]  num_obj = '0;
    logic        start = 1'b0;
    logic        busy;
    logic [15:0] det_x1, det_y1, det_x2, det_y2, det_vx1, det_vy1, det_vx2, det_vy2, det_r2;
    logic        det_in_rdy;
    logic        det_trial = 1'b0;
    logic        det_out_rdy = 1'b0;
    logic        pair_valid;
    logic [2:0]  pair_i, pair_j;
    logic        pair_hit, pair_timeout;
    logic [7:0]  hit_count;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // detector model configuration
    int model_lat     = 10;
    bit model_resp    = 1'b1;
    bit model_hit_all = 1'b0;
    int mcnt          = 0;

    // monitor records
    int          n_pv = 0, n_ops = 0, done_cnt = 0, done_cyc = -1, rdy_high_cnt = 0;
    int          busy_rise_cyc = -1, busy_fall_cyc = -1;
    bit          rdy_prev = 1'b0, busy_prev = 1'b0;
    int          pv_cyc [256];
    logic [2:0]  pv_i [256], pv_j [256];
    logic        pv_hit [256], pv_tmo [256];
    logic [7:0]  pv_hc [256];
    int          op_cyc [256];
    logic [15:0] op_x1 [256], op_y1 [256], op_vx1 [256], op_vy1 [256];
    logic [15:0] op_x2 [256], op_y2 [256], op_vx2 [256], op_vy2 [256], op_r2 [256];

    coll_pair_issuer dut (
        .clock        (clock),
        .reset        (reset),
        .obj_wr_en    (obj_wr_en),
        .obj_wr_idx   (obj_wr_idx),
        .obj_wr_x     (obj_wr_x),
        .obj_wr_y     (obj_wr_y),
        .obj_wr_vx    (obj_wr_vx),
        .obj_wr_vy    (obj_wr_vy),
        .r2_in        (r2_in),
        .num_obj      (num_obj),
        .start        (start),
        .busy         (busy),
        .det_x1       (det_x1),
        .det_y1       (det_y1),
        .det_x2       (det_x2),
        .det_y2       (det_y2),
        .det_vx1      (det_vx1),
        .det_vy1      (det_vy1),
        .det_vx2      (det_vx2),
        .det_vy2      (det_vy2),
        .det_r2       (det_r2),
        .det_in_rdy   (det_in_rdy),
        .det_trial    (det_trial),
        .det_out_rdy  (det_out_rdy),
        .pair_valid   (pair_valid),
        .pair_i       (pair_i),
        .pair_j       (pair_j),
        .pair_hit     (pair_hit),
        .pair_timeout (pair_timeout),
        .hit_count    (hit_count),
        .done         (done)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Detector: strobes once after model_lat cycles of det_in_rdy; hits (0,2) by x identity.
    always @(negedge clock) begin
        if (det_in_rdy && model_resp) begin
            mcnt++;
            det_out_rdy = (mcnt == model_lat);
            det_trial   = model_hit_all || (det_x1 == 16'd0 && det_x2 == 16'd2);
        end else begin
            mcnt        = 0;
            det_out_rdy = 1'b0;
            det_trial   = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (det_in_rdy) begin
            rdy_high_cnt++;
            if (!rdy_prev && n_ops < 256) begin
                op_cyc[n_ops] = cyc;
                op_x1[n_ops] = det_x1;   op_y1[n_ops] = det_y1;
                op_vx1[n_ops] = det_vx1; op_vy1[n_ops] = det_vy1;
                op_x2[n_ops] = det_x2;   op_y2[n_ops] = det_y2;
                op_vx2[n_ops] = det_vx2; op_vy2[n_ops] = det_vy2;
                op_r2[n_ops] = det_r2;
                n_ops++;
            end
        end
        rdy_prev = det_in_rdy;
        if (pair_valid && n_pv < 256) begin
            pv_cyc[n_pv] = cyc; pv_i[n_pv] = pair_i; pv_j[n_pv] = pair_j;
            pv_hit[n_pv] = pair_hit; pv_tmo[n_pv] = pair_timeout; pv_hc[n_pv] = hit_count;
            n_pv++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy && !busy_prev) busy_rise_cyc = cyc;
        if (!busy && busy_prev) busy_fall_cyc = cyc;
        busy_prev = busy;
    end

    task automatic write_obj(input logic [2:0] idx, input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] vx, input logic [15:0] vy);
        @(negedge clock);
        obj_wr_en = 1'b1; obj_wr_idx = idx;
        obj_wr_x = x; obj_wr_y = y; obj_wr_vx = vx; obj_wr_vy = vy;
        @(negedge clock);
        obj_wr_en = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] n, input logic [15:0] r2, output int st);
        @(negedge clock);
        start = 1'b1; num_obj = n; r2_in = r2; st = cyc;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int db, input int budget, input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock); #1;
            if (done_cnt > db) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_done: no done pulse within %0d cycles", nm, budget);
        end
        repeat (2) @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (det_in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_in_rdy: got %b want 0", det_in_rdy); end
        n_checks++; if (pair_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: pv=%b done=%b want 0 0", pair_valid, done); end
        n_checks++; if (hit_count !== 8'd0) begin n_fail++; $display("FAIL reset_hit_count: got %0d want 0", hit_count); end
        n_checks++; if (det_x1 !== 16'd0 || det_r2 !== 16'd0 || det_vy2 !== 16'd0) begin n_fail++; $display("FAIL reset_operands: x1=%h r2=%h vy2=%h want 0", det_x1, det_r2, det_vy2); end
        n_checks++; if (pair_i !== 3'd0 || pair_j !== 3'd0 || pair_hit !== 1'b0 || pair_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_pair: i=%0d j=%0d hit=%b tmo=%b want 0", pair_i, pair_j, pair_hit, pair_timeout); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_three_objects();
        int st, pb, ob, db;
        int ei [3], ej [3], eh [3];
        ei = '{0, 0, 1}; ej = '{1, 2, 2}; eh = '{0, 1, 0};
        model_lat = 10; model_resp = 1'b1; model_hit_all = 1'b0;
        for (int k = 0; k < 3; k++)
            write_obj(3'(k), 16'(k), 16'(16'h100 + k), 16'(16'h200 + k), 16'(16'h300 + k));
        #1; pb = n_pv; ob = n_ops; db = done_cnt;
        do_start(4'd3, 16'h0ABC, st);
        wait_done(db, 200, "three");
        n_checks++; if (n_pv - pb !== 3) begin n_fail++; $display("FAIL three_count: got %0d pairs want 3", n_pv - pb); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (pv_i[pb+k] !== 3'(ei[k]) || pv_j[pb+k] !== 3'(ej[k]) || pv_hit[pb+k] !== eh[k][0] || pv_tmo[pb+k] !== 1'b0) begin
                n_fail++;
                $display("FAIL three_pair%0d: got (%0d,%0d) hit=%b tmo=%b want (%0d,%0d) hit=%0d tmo=0",
                         k, pv_i[pb+k], pv_j[pb+k], pv_hit[pb+k], pv_tmo[pb+k], ei[k], ej[k], eh[k]);
            end
        end
        n_checks++; if (hit_count !== 8'd1) begin n_fail++; $display("FAIL three_hit_count: got %0d want 1", hit_count); end
        n_checks++; if (pv_hc[pb+1] !== 8'd1 || pv_hc[pb] !== 8'd0) begin n_fail++; $display("FAIL three_hc_timing: got %0d,%0d want 0,1", pv_hc[pb], pv_hc[pb+1]); end
        n_checks++; if (done_cnt - db !== 1) begin n_fail++; $display("FAIL three_done_once: got %0d want 1", done_cnt - db); end
        n_checks++; if (op_cyc[ob] - st !== 2) begin n_fail++; $display("FAIL three_first_rdy: got %0d cycles want 2", op_cyc[ob] - st); end
        n_checks++; if (pv_cyc[pb] - st !== 13 || pv_cyc[pb+1] - pv_cyc[pb] !== 13) begin n_fail++; $display("FAIL three_pair_timing: got %0d,%0d want 13,13", pv_cyc[pb] - st, pv_cyc[pb+1] - pv_cyc[pb]); end
        n_checks++; if (done_cyc - pv_cyc[pb+2] !== 2) begin n_fail++; $display("FAIL three_done_lat: got %0d want 2", done_cyc - pv_cyc[pb+2]); end
        n_checks++; if (busy_fall_cyc - done_cyc !== 1) begin n_fail++; $display("FAIL three_busy_fall: got %0d want 1", busy_fall_cyc - done_cyc); end
        n_checks++;
        if (op_x1[ob] !== 16'h0000 || op_y1[ob] !== 16'h0100 || op_vx1[ob] !== 16'h0200 || op_vy1[ob] !== 16'h0300) begin
            n_fail++;
            $display("FAIL three_ops1: got %h %h %h %h want 0000 0100 0200 0300", op_x1[ob], op_y1[ob], op_vx1[ob], op_vy1[ob]);
        end
        n_checks++;
        if (op_x2[ob+1] !== 16'h0002 || op_y2[ob+1] !== 16'h0102 || op_vx2[ob+1] !== 16'h0202 || op_vy2[ob+1] !== 16'h0302 || op_r2[ob+1] !== 16'h0ABC) begin
            n_fail++;
            $display("FAIL three_ops2: got %h %h %h %h r2=%h want 0002 0102 0202 0302 r2=0abc",
                     op_x2[ob+1], op_y2[ob+1], op_vx2[ob+1], op_vy2[ob+1], op_r2[ob+1]);
        end
    endtask

    task automatic test_single_object();
        int st, pb, db, rb;
        #1; pb = n_pv; db = done_cnt; rb = rdy_high_cnt;
        do_start(4'd1, 16'h0001, st);
        wait_done(db, 20, "single");
        n_checks++; if (rdy_high_cnt !== rb) begin n_fail++; $display("FAIL single_no_rdy: got %0d rdy cycles want 0", rdy_high_cnt - rb); end
        n_checks++; if (n_pv !== pb) begin n_fail++; $display("FAIL single_no_pairs: got %0d want 0", n_pv - pb); end
        n_checks++; if (busy_rise_cyc - st !== 1) begin n_fail++; $display("FAIL single_busy_rise: got %0d want 1", busy_rise_cyc - st); end
        n_checks++; if (done_cyc - busy_rise_cyc !== 1) begin n_fail++; $display("FAIL single_done_lat: got %0d want 1", done_cyc - busy_rise_cyc); end
        n_checks++; if (busy_fall_cyc - done_cyc !== 1) begin n_fail++; $display("FAIL single_busy_fall: got %0d want 1", busy_fall_cyc - done_cyc); end
        n_checks++; if (hit_count !== 8'd0) begin n_fail++; $display("FAIL single_hit_count: got %0d want 0", hit_count); end
    endtask

    task automatic test_all_pairs(input logic [3:0] n, input int lat, input string nm);
        int st, pb, db, k;
        model_lat = lat; model_resp = 1'b1; model_hit_all = 1'b1;
        for (int m = 0; m < 8; m++)
            write_obj(3'(m), 16'(m), 16'(16'h10 + m), 16'(16'h20 + m), 16'(16'h30 + m));
        #1; pb = n_pv; db = done_cnt;
        do_start(n, 16'h7777, st);
        wait_done(db, 2000, nm);
        n_checks++; if (n_pv - pb !== 28) begin n_fail++; $display("FAIL %s_count: got %0d want 28", nm, n_pv - pb); end
        k = 0;
        for (int i = 0; i < 7; i++) begin
            for (int j = i + 1; j < 8; j++) begin
                n_checks++;
                if (pv_i[pb+k] !== 3'(i) || pv_j[pb+k] !== 3'(j) || pv_hit[pb+k] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_pair%0d: got (%0d,%0d) hit=%b want (%0d,%0d) hit=1", nm, k, pv_i[pb+k], pv_j[pb+k], pv_hit[pb+k], i, j);
                end
                k++;
            end
        end
        n_checks++; if (hit_count !== 8'd28) begin n_fail++; $display("FAIL %s_hit_count: got %0d want 28", nm, hit_count); end
        model_hit_all = 1'b0;
    endtask

    task automatic test_timeout();
        int st, pb, db, rb;
        model_resp = 1'b0;
        #1; pb = n_pv; db = done_cnt; rb = rdy_high_cnt;
        do_start(4'd2, 16'h0042, st);
        wait_done(db, 200, "timeout");
        n_checks++; if (rdy_high_cnt - rb !== 64) begin n_fail++; $display("FAIL timeout_rdy_len: got %0d want 64", rdy_high_cnt - rb); end
        n_checks++; if (n_pv - pb !== 1) begin n_fail++; $display("FAIL timeout_count: got %0d want 1", n_pv - pb); end
        n_checks++;
        if (pv_tmo[pb] !== 1'b1 || pv_hit[pb] !== 1'b0 || pv_i[pb] !== 3'd0 || pv_j[pb] !== 3'd1) begin
            n_fail++;
            $display("FAIL timeout_pair: got (%0d,%0d) hit=%b tmo=%b want (0,1) hit=0 tmo=1", pv_i[pb], pv_j[pb], pv_hit[pb], pv_tmo[pb]);
        end
        n_checks++; if (done_cnt - db !== 1) begin n_fail++; $display("FAIL timeout_done: got %0d want 1", done_cnt - db); end
        model_resp = 1'b1;
    endtask

    task automatic test_reset_mid_scan();
        int st, pb, ob, db;
        bit hit_02 = 1'b0;
        model_lat = 20; model_resp = 1'b1; model_hit_all = 1'b0;
        for (int m = 0; m < 3; m++)
            write_obj(3'(m), 16'(m), 16'hAAAA, 16'hBBBB, 16'hCCCC);
        #1; pb = n_pv; db = done_cnt;
        do_start(4'd3, 16'h1111, st);
        for (int k = 0; k < 200; k++) begin
            @(negedge clock); #1;
            if (det_in_rdy && det_x2 == 16'd2) begin
                hit_02 = 1'b1;
                break;
            end
        end
        n_checks++; if (!hit_02) begin n_fail++; $display("FAIL rstmid_reach: pair (0,2) never issued within 200 cycles"); end
        reset = 1'b1;
        @(negedge clock); #1;
        n_checks++; if (busy !== 1'b0 || det_in_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_abort: busy=%b in_rdy=%b want 0 0", busy, det_in_rdy); end
        n_checks++; if (hit_count !== 8'd0) begin n_fail++; $display("FAIL rstmid_hit_count: got %0d want 0", hit_count); end
        reset = 1'b0;
        repeat (30) @(negedge clock);
        #1;
        n_checks++; if (done_cnt !== db) begin n_fail++; $display("FAIL rstmid_no_done: got %0d done pulses want 0", done_cnt - db); end
        n_checks++; if (n_pv - pb !== 1) begin n_fail++; $display("FAIL rstmid_pairs: got %0d want 1", n_pv - pb); end
        pb = n_pv; ob = n_ops; db = done_cnt;
        do_start(4'd2, 16'h55AA, st);
        wait_done(db, 200, "rstmid_rescan");
        n_checks++; if (n_pv - pb !== 1 || pv_i[pb] !== 3'd0 || pv_j[pb] !== 3'd1) begin n_fail++; $display("FAIL rstmid_rescan_pair: got %0d pairs (%0d,%0d) want 1 (0,1)", n_pv - pb, pv_i[pb], pv_j[pb]); end
        n_checks++;
        if (op_x1[ob] !== 16'd0 || op_x2[ob] !== 16'd0 || op_y1[ob] !== 16'd0 || op_vy2[ob] !== 16'd0 || op_r2[ob] !== 16'h55AA) begin
            n_fail++;
            $display("FAIL rstmid_table_clear: x1=%h x2=%h y1=%h vy2=%h r2=%h want 0 0 0 0 55aa", op_x1[ob], op_x2[ob], op_y1[ob], op_vy2[ob], op_r2[ob]);
        end
    endtask

    task automatic test_busy_write();
        int st, st2, pb, ob, db;
        model_lat = 5; model_resp = 1'b1; model_hit_all = 1'b0;
        for (int m = 0; m < 3; m++)
            write_obj(3'(m), 16'(16'h10 + m), 16'h0, 16'h0, 16'h0);
        #1; pb = n_pv; db = done_cnt;
        do_start(4'd3, 16'h0003, st);
        repeat (4) @(negedge clock);
        write_obj(3'd1, 16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        do_start(4'd2, 16'h0009, st2);
        wait_done(db, 300, "busywr");
        n_checks++; if (n_pv - pb !== 3) begin n_fail++; $display("FAIL busywr_extra_start: got %0d pairs want 3", n_pv - pb); end
        n_checks++; if (done_cnt - db !== 1) begin n_fail++; $display("FAIL busywr_done_once: got %0d want 1", done_cnt - db); end
        pb = n_pv; ob = n_ops; db = done_cnt;
        do_start(4'd3, 16'h0003, st);
        wait_done(db, 300, "busywr_rescan");
        n_checks++; if (pv_i[pb+2] !== 3'd1 || pv_j[pb+2] !== 3'd2) begin n_fail++; $display("FAIL busywr_pair: got (%0d,%0d) want (1,2)", pv_i[pb+2], pv_j[pb+2]); end
        n_checks++; if (op_x1[ob+2] !== 16'h0011 || op_y1[ob+2] !== 16'h0000) begin n_fail++; $display("FAIL busywr_dropped: x1=%h y1=%h want 0011 0000", op_x1[ob+2], op_y1[ob+2]); end
    endtask

    initial begin
        test_reset();
        test_three_objects();
        test_single_object();
        test_all_pairs(4'd8, 2, "all8");
        test_all_pairs(4'd15, 1, "clamp");
        test_timeout();
        test_reset_mid_scan();
        test_busy_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/coll_pair_issuer.md
Name: coll_pair_issuer

Overview:
- Initiator side of the collision-detector operand handshake. Holds a table of object states: position, velocity, and one global radius-squared term.
- On a start pulse it walks every unordered object pair (i<j) and presents the pair's operands to a collision detector. It waits for that detector's result and streams each pair verdict out with a summary count.
- Sits between the object-state loader and the collision detector. It is the block that drives x1..r2 and in_rdy and consumes trial and out_rdy.

Parameters:
- N_OBJ, 8, number of object table entries.
- IDX_W, 3, index width; ceil(log2(N_OBJ)).
- W, 16, operand width of every coordinate, velocity and r2.
- TIMEOUT, 64, cycles to wait for det_out_rdy before abandoning a pair.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- obj_wr_en  in  1  write one table entry this cycle.
- obj_wr_idx  in  IDX_W  entry index.
- obj_wr_x, obj_wr_y, obj_wr_vx, obj_wr_vy  in  W each  entry fields.
- r2_in  in  W  radius-squared value, latched at start.
- num_obj  in  IDX_W+1  active object count, latched at start.
- start  in  1  one-cycle pulse that begins a scan.
- busy  out  1  high from the start-accept cycle until the done cycle inclusive.
- det_x1, det_y1, det_x2, det_y2, det_vx1, det_vy1, det_vx2, det_vy2, det_r2  out  W each  operands to the detector.
- det_in_rdy  out  1  request to the detector.
- det_trial  in  1  detector verdict; valid when det_out_rdy=1.
- det_out_rdy  in  1  one-cycle result strobe from the detector.
- pair_valid  out  1  one-cycle strobe per completed pair.
- pair_i, pair_j  out  IDX_W each  indices of the reported pair.
- pair_hit  out  1  collision verdict; 0 on timeout.
- pair_timeout  out  1  the reported pair timed out.
- hit_count  out  8  collisions in the current scan; saturates at 255.
- done  out  1  one-cycle pulse when the scan completes.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, pair indices to 0, timeout counter to 0, table entries to 0. Reset mid-scan aborts the scan immediately, with no done pulse.
- Table writes are accepted only in IDLE. Writes while busy are dropped. If obj_wr_idx>=N_OBJ the write is dropped.
- FSM states:
  - IDLE: on start, latch r2_in and num_obj, set i=0, j=1, clear hit_count, raise busy, go to LOAD. If num_obj<2, go to DONE instead.
  - LOAD: drive det_* from table[i] (the 1 operands) and table[j] (the 2 operands), and det_r2 from the latched r2. Go to ISSUE.
  - ISSUE: det_in_rdy=1. Operands are held stable for the whole state. The timeout counter increments each cycle.
    - det_out_rdy=1: capture det_trial, go to REPORT.
    - Counter reaches TIMEOUT-1 with no strobe: pair_hit=0, pair_timeout=1, go to REPORT.
  - REPORT: det_in_rdy=0. Pulse pair_valid with the current i, j, pair_hit and pair_timeout. Increment hit_count if pair_hit (saturating). Clear the timeout counter. Go to NEXT.
  - NEXT: if j<num_obj-1, then j++. Otherwise, if i<num_obj-2, then i++ and j=i+1. Otherwise go to DONE. If the scan continues, go to LOAD.
  - DONE: pulse done for 1 cycle; busy is still high this cycle. Go to IDLE; busy drops the next cycle.
- det_in_rdy drops in the cycle after det_out_rdy is seen, and stays low for at least 2 cycles (REPORT, NEXT) before the next pair. This lets the detector restart its internal sequence.
- A det_out_rdy outside ISSUE is ignored.
- start while busy is ignored.
- num_obj>N_OBJ is clamped to N_OBJ.
- Pair order: (0,1),(0,2)..(0,n-1),(1,2)..(n-2,n-1). Total n(n-1)/2 pairs.
- Latency:
  - start to first det_in_rdy: 2 cycles.
  - Per pair: detector latency + 3 cycles.
  - Last pair_valid to done: 2 cycles.
- Arithmetic: no operand arithmetic. Operands pass through unsigned and unmodified.

Decomposition:
- Shared package coll_pkg holds:
  - the operand width W;
  - the object-state record: x, y, vx, vy;
  - the FSM state enum: IDLE, LOAD, ISSUE, REPORT, NEXT, DONE;
  - the default TIMEOUT constant.
- One natural sub-module: coll_obj_table. It is an N_OBJ x 4W register file with one write port, two asynchronous read ports (i, j) and synchronous clear on reset.

Test Plan:
- Load 3 objects, num_obj=3, detector model answers after 10 cycles with trial=1 only for (0,2) -> pair_valid for (0,1),(0,2),(1,2) in order; pair_hit=0,1,0; hit_count=1; done exactly once; det_in_rdy first high 2 cycles after start.
- num_obj=1, start -> no det_in_rdy; done one cycle after busy rises; hit_count=0.
- num_obj=8, detector always trial=1 -> 28 pair_valid strobes, last pair (6,7), hit_count=28.
- Detector never responds, TIMEOUT=64, num_obj=2 -> det_in_rdy high exactly 64 cycles; pair_timeout=1, pair_hit=0; done follows.
- Assert reset while in ISSUE on pair (0,2) -> next cycle busy=0, det_in_rdy=0, no done. Table reads as 0 afterwards, and a new start scans cleanly.
- Write table[1].x=0x1234 while busy -> write dropped; after scan, det_x1 for pair (1,2) in the next scan shows the old value. Extra start during scan ignored.
